// File: rtl/quad_decoder.sv
// quad_decoder
// Quadrature decoder for an incremental encoder's A/B channels. The raw
// channels are synchronized into the clk domain, and every legal Gray-code
// transition is decoded into an up or down step (x4 decoding). The block
// keeps its own wrapping position count. Load and clear control the count
// the same way as on the up/down counter: load beats clear, and clear beats
// stepping. If both channels change in one sample, a sticky error is set.
//
// Parameters:
//   WIDTH        position counter width in bits
//   SYNC_STAGES  flip-flop stages per channel in the input synchronizer (2..4)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   a_in     raw encoder channel A (asynchronous)
//   b_in     raw encoder channel B (asynchronous)
//   load     synchronous load of din into count (highest priority)
//   clr      synchronous clear of count
//   din      load value
//   err_clr  synchronous clear of the sticky err flag
//   count    position, wraps modulo 2^WIDTH
//   dir      direction of last legal step, 1 = up, 0 = down
//   step     one-cycle pulse per legal transition
//   err      sticky illegal-transition flag
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    typedef enum logic [1:0] {
        EV_NONE,
        EV_UP,
        EV_DOWN,
        EV_ILLEGAL
    } decodeEvent_t;

    // The synchronizer outputs reset to zero. They only hold real pin samples
    // after SYNC_STAGES clocks. Priming therefore lasts SYNC_STAGES+1 clocks,
    // so that prevState has caught up with a settled sample before decoding
    // starts. This keeps the reset-value-to-pin-value jump from being decoded
    // as a step or an illegal transition.
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] aSyncReg;
    logic [SYNC_STAGES-1:0] bSyncReg;
    logic [1:0]             curState;
    logic [1:0]             prevState;
    logic [2:0]             primeCnt;
    logic                   primed;
    decodeEvent_t           decodeEvent;

    // Plain shift-register synchronizer for each channel. New samples enter
    // at bit 0, and the settled value is taken from the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSyncReg <= '0;
            bSyncReg <= '0;
        end else begin
            aSyncReg <= {aSyncReg[SYNC_STAGES-2:0], a_in};
            bSyncReg <= {bSyncReg[SYNC_STAGES-2:0], b_in};
        end
    end

    assign curState = {aSyncReg[SYNC_STAGES-1], bSyncReg[SYNC_STAGES-1]};

    // Classify the move from prevState to curState. If both bits flip, the
    // move is illegal. Otherwise it is a move of one Gray step: it is up if
    // it follows the sequence 00->10->11->01->00, and down if it does not.
    always_comb begin
        decodeEvent = EV_NONE;
        if (primed && (curState != prevState)) begin
            if ((curState[1] != prevState[1]) && (curState[0] != prevState[0])) begin
                decodeEvent = EV_ILLEGAL;
            end else begin
                case (prevState)
                    2'b00:   decodeEvent = (curState == 2'b10) ? EV_UP : EV_DOWN;
                    2'b10:   decodeEvent = (curState == 2'b11) ? EV_UP : EV_DOWN;
                    2'b11:   decodeEvent = (curState == 2'b01) ? EV_UP : EV_DOWN;
                    default: decodeEvent = (curState == 2'b00) ? EV_UP : EV_DOWN;
                endcase
            end
        end
    end

    // This block holds the decoder state and the registered outputs. prevState
    // advances every clock, including during priming and when load or clr is
    // asserted. step, dir and err always reflect the decoded event, even
    // when load or clr drops that event from the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevState <= 2'b00;
            primeCnt  <= '0;
            primed    <= 1'b0;
            count     <= '0;
            dir       <= 1'b1;
            step      <= 1'b0;
            err       <= 1'b0;
        end else begin
            prevState <= curState;

            if (!primed) begin
                if (primeCnt == PRIME_LAST) begin
                    primed <= 1'b1;
                end else begin
                    primeCnt <= primeCnt + 3'd1;
                end
            end

            step <= (decodeEvent == EV_UP) || (decodeEvent == EV_DOWN);

            if (decodeEvent == EV_UP) begin
                dir <= 1'b1;
            end else if (decodeEvent == EV_DOWN) begin
                dir <= 1'b0;
            end

            if (decodeEvent == EV_ILLEGAL) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            if (load) begin
                count <= din;
            end else if (clr) begin
                count <= '0;
            end else if (decodeEvent == EV_UP) begin
                count <= count + WIDTH'(1);
            end else if (decodeEvent == EV_DOWN) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder
// Self-checking bench for quad_decoder. The bench drives the encoder pins
// as a position on the Gray wheel. A behavioural model tracks the
// position-difference arithmetic, and the outputs are compared with the
// model after every clock. Directed constant checks cover the key scenarios.
module tb_quad_decoder;

    localparam int WIDTH = 8;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rstN;
    logic             aIn;
    logic             bIn;
    logic             loadIn;
    logic             clrIn;
    logic [WIDTH-1:0] dinIn;
    logic             errClrIn;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    logic [WIDTH-1:0] mCount;
    bit               mDir;
    bit               mStep;
    bit               mErr;
    bit [1:0]         mPrev;
    bit [1:0]         syncQ[$];
    int               mEdges;

    int pinPos;
    int firstLat;
    int stepTotal;

    // The clock period is 10 time units.
    always #5 clk = ~clk;

    // Instantiate the design under test.
    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .rst_n   (rstN),
        .a_in    (aIn),
        .b_in    (bIn),
        .load    (loadIn),
        .clr     (clrIn),
        .din     (dinIn),
        .err_clr (errClrIn),
        .count   (count),
        .dir     (dir),
        .step    (step),
        .err     (err)
    );

    // Convert a wheel position to pin levels {A,B}.
    function automatic bit [1:0] grayOf(int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Convert pin levels {A,B} back to a wheel position.
    function automatic int posOf(bit [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Put the model into its reset state.
    task automatic modelReset();
        syncQ.delete();
        repeat (SS) syncQ.push_back(2'b00);
        mPrev  = 2'b00;
        mEdges = 0;
        mCount = '0;
        mDir   = 1'b1;
        mStep  = 1'b0;
        mErr   = 1'b0;
    endtask

    // Update the model for one rising edge. The pins are seen SS edges late.
    // The position difference modulo 4 decides the event:
    // 1 = up, 3 = down, 2 = illegal, 0 = none.
    task automatic modelEdge();
        bit [1:0] s;
        int d;
        s = syncQ.pop_front();
        syncQ.push_back({aIn, bIn});
        if (mEdges < SS + 1) begin
            mEdges++;
            d = 0;
        end else begin
            d = (posOf(s) - posOf(mPrev) + 4) % 4;
        end
        mPrev = s;
        mStep = (d == 1) || (d == 3);
        if (d == 1) mDir = 1'b1;
        if (d == 3) mDir = 1'b0;
        if (d == 2) mErr = 1'b1;
        else if (errClrIn) mErr = 1'b0;
        if (loadIn) mCount = dinIn;
        else if (clrIn) mCount = '0;
        else if (d == 1) mCount = mCount + 8'd1;
        else if (d == 3) mCount = mCount - 8'd1;
    endtask

    // Compare every DUT output with the model.
    task automatic checkOutput(string tag);
        checkCount++;
        assert (count === mCount) begin passCount++; end
        else begin failCount++; $error("[TB] FAIL %s count: observed %0h expected %0h", tag, count, mCount); end
        checkCount++;
        assert (step === mStep) begin passCount++; end
        else begin failCount++; $error("[TB] FAIL %s step: observed %0b expected %0b", tag, step, mStep); end
        checkCount++;
        assert (dir === mDir) begin passCount++; end
        else begin failCount++; $error("[TB] FAIL %s dir: observed %0b expected %0b", tag, dir, mDir); end
        checkCount++;
        assert (err === mErr) begin passCount++; end
        else begin failCount++; $error("[TB] FAIL %s err: observed %0b expected %0b", tag, err, mErr); end
    endtask

    // Directed comparison of an observed value with a fixed expected value.
    task automatic checkValue(string tag, logic [31:0] observed, logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin passCount++; end
        else begin failCount++; $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected); end
    endtask

    // Drive one clock of stimulus, update the model and check the outputs.
    task automatic applyStimulus(bit ld, bit cl, logic [WIDTH-1:0] d, bit ec, string tag);
        {aIn, bIn} = grayOf(pinPos);
        loadIn     = ld;
        clrIn      = cl;
        dinIn      = d;
        errClrIn   = ec;
        @(posedge clk);
        if (rstN) modelEdge();
        #1;
        checkOutput(tag);
    endtask

    // Hold the pins for n clocks with no control inputs asserted.
    task automatic dwell(int n, string tag);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        rstN = 1'b0; pinPos = 0;
        aIn = 1'b0; bIn = 1'b0; loadIn = 1'b0; clrIn = 1'b0; dinIn = '0; errClrIn = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        checkValue("resetDir", 32'(dir), 32'd1);
        rstN = 1'b1;
        dwell(6, "prime");

        // Run four full up cycles with 10 clocks per phase. Measure the
        // latency of the first step pulse and count the pulses.
        firstLat = -1; stepTotal = 0;
        for (int t = 0; t < 16; t++) begin
            pinPos = (pinPos + 1) & 3;
            for (int c = 1; c <= 10; c++) begin
                applyStimulus(1'b0, 1'b0, '0, 1'b0, "up4");
                stepTotal += int'(step);
                if (t == 0 && step === 1'b1 && firstLat < 0) firstLat = c;
            end
        end
        checkValue("latency", 32'(firstLat), 32'(SS + 1));
        checkValue("upSteps", 32'(stepTotal), 32'd16);
        checkValue("upCount", 32'(count), 32'd16);
        checkValue("upDir", 32'(dir), 32'd1);
        checkValue("upErr", 32'(err), 32'd0);

        // Load 2, then make three down transitions so the count wraps below zero.
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b0, "load2");
        dwell(1, "load2");
        for (int t = 0; t < 3; t++) begin
            pinPos = (pinPos + 3) & 3;
            dwell(6, "down3");
        end
        checkValue("downCount", 32'(count), 32'd255);
        checkValue("downDir", 32'(dir), 32'd0);
        checkValue("downErr", 32'(err), 32'd0);

        // Make an illegal transition.
        pinPos = (pinPos + 2) & 3;
        dwell(6, "illegal");
        checkValue("illegalErr", 32'(err), 32'd1);
        checkValue("illegalCount", 32'(count), 32'd255);
        checkValue("illegalStep", 32'(step), 32'd0);

        // Assert err_clr in the same cycle as another illegal transition. The set wins.
        pinPos = (pinPos + 2) & 3;
        dwell(2, "illegal2");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, "errClrIllegal");
        checkValue("errSetWins", 32'(err), 32'd1);
        dwell(3, "idle");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, "errClr");
        checkValue("errCleared", 32'(err), 32'd0);

        // Assert load and clr together, coincident with an up step.
        pinPos = (pinPos + 1) & 3;
        dwell(2, "preStep");
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, "loadClrStep");
        checkValue("loadWinsCount", 32'(count), 32'hA5);
        checkValue("loadStepPulse", 32'(step), 32'd1);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, "clrOnly");
        checkValue("clrCount", 32'(count), 32'd0);
        dwell(3, "idle");

        // Load 255, then make one up step so the count wraps to zero.
        applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0, "loadFF");
        pinPos = (pinPos + 1) & 3;
        dwell(5, "wrapUp");
        checkValue("wrapCount", 32'(count), 32'd0);

        // Random walk with occasional illegal jumps and control pulses.
        for (int m = 0; m < 60; m++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) pinPos = (pinPos + 2) & 3;
            else if (r < 11) pinPos = (pinPos + 1) & 3;
            else pinPos = (pinPos + 3) & 3;
            repeat ($urandom_range(1, 6)) begin
                applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                              8'($urandom), $urandom_range(0, 9) == 0, "random");
            end
        end

        // Reset with the pins held static at 11. There must be no step or
        // err after priming.
        #2; rstN = 1'b0; pinPos = 2; {aIn, bIn} = grayOf(pinPos);
        modelReset();
        #1; checkOutput("reset11");
        #2; rstN = 1'b1;
        stepTotal = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, "static11");
            stepTotal += int'(step);
        end
        checkValue("static11Steps", 32'(stepTotal), 32'd0);
        checkValue("static11Err", 32'(err), 32'd0);

        // Assert reset asynchronously in the middle of an up sequence.
        for (int t = 0; t < 3; t++) begin
            pinPos = (pinPos + 1) & 3;
            dwell(6, "preAsync");
        end
        #2; rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncReset");
        checkValue("asyncCount", 32'(count), 32'd0);
        checkValue("asyncDir", 32'(dir), 32'd1);
        checkValue("asyncStep", 32'(step), 32'd0);
        checkValue("asyncErr", 32'(err), 32'd0);
        #2; rstN = 1'b1;
        dwell(4, "reprime");
        stepTotal = 0;
        for (int t = 0; t < 8; t++) begin
            pinPos = (pinPos + 1) & 3;
            for (int c = 0; c < 6; c++) begin
                applyStimulus(1'b0, 1'b0, '0, 1'b0, "resume");
                stepTotal += int'(step);
            end
        end
        checkValue("resumeSteps", 32'(stepTotal), 32'd8);
        checkValue("resumeCount", 32'(count), 32'd8);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
